// File: rtl/spu_wb_arbiter.sv
// spu_wb_arbiter: round-robin Wishbone classic arbiter with bus-hang watchdog
module spu_wb_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int WB_ADR_WIDTH   = 37,
  parameter int WB_DAT_WIDTH   = 64,
  parameter int WB_SEL_WIDTH   = WB_DAT_WIDTH/8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [WB_DAT_WIDTH-1:0] TIMEOUT_DATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic [NUM_MASTERS-1:0][WB_ADR_WIDTH-1:0]   s_wb_adr_i,
  input  logic [NUM_MASTERS-1:0][WB_DAT_WIDTH-1:0]   s_wb_dat_i,
  input  logic [NUM_MASTERS-1:0][WB_SEL_WIDTH-1:0]   s_wb_sel_i,
  input  logic [NUM_MASTERS-1:0]                     s_wb_we_i,
  input  logic [NUM_MASTERS-1:0]                     s_wb_stb_i,
  output logic [WB_DAT_WIDTH-1:0]                    s_wb_dat_o,
  output logic [NUM_MASTERS-1:0]                     s_wb_ack_o,
  output logic [WB_ADR_WIDTH-1:0]                    m_wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0]                    m_wb_dat_o,
  output logic [WB_SEL_WIDTH-1:0]                    m_wb_sel_o,
  output logic                                       m_wb_we_o,
  output logic                                       m_wb_stb_o,
  input  logic [WB_DAT_WIDTH-1:0]                    m_wb_dat_i,
  input  logic                                       m_wb_ack_i,
  output logic                                       busy,
  output logic [$clog2(NUM_MASTERS)-1:0]             grant,
  output logic [15:0]                                timeout_count
);
  localparam int GW  = $clog2(NUM_MASTERS);
  localparam int WDW = $clog2(TIMEOUT_CYCLES+1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               r_state;
  logic [GW-1:0]        r_grant;
  logic [GW-1:0]        r_last_grant;
  logic [WDW-1:0]       r_wd_cnt;
  logic [15:0]          r_timeout_count;
  logic                 w_timeout;
  logic                 w_done;
  logic [NUM_MASTERS-1:0] w_others;
  logic [GW:0]          w_idle_pick;
  logic [GW:0]          w_next_pick;

  // First requester searching upward from base+1 with wrap; MSB flags a hit.
  function automatic logic [GW:0] pick(input logic [NUM_MASTERS-1:0] req, input logic [GW-1:0] base);
    logic [GW:0]   r;
    logic [GW-1:0] ti;
    r = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      ti = GW'((int'(base) + i) % NUM_MASTERS);
      if (req[ti]) r = {1'b1, ti};
    end
    return r;
  endfunction

  assign busy          = (r_state == BUSY);
  assign grant         = r_grant;
  assign timeout_count = r_timeout_count;
  assign w_timeout     = busy && (r_wd_cnt == WDW'(TIMEOUT_CYCLES));
  assign m_wb_adr_o    = s_wb_adr_i[r_grant];
  assign m_wb_dat_o    = s_wb_dat_i[r_grant];
  assign m_wb_sel_o    = s_wb_sel_i[r_grant];
  assign m_wb_we_o     = s_wb_we_i[r_grant];
  assign m_wb_stb_o    = busy && s_wb_stb_i[r_grant] && !w_timeout;
  assign w_done        = w_timeout || (m_wb_ack_i && m_wb_stb_o);
  assign s_wb_dat_o    = w_timeout ? TIMEOUT_DATA : m_wb_dat_i;
  assign w_idle_pick   = pick(s_wb_stb_i, r_last_grant);
  assign w_next_pick   = pick(w_others, r_grant);

  always_comb begin
    s_wb_ack_o          = '0;
    s_wb_ack_o[r_grant] = w_done;
    w_others            = s_wb_stb_i;
    w_others[r_grant]   = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_grant         <= '0;
      r_last_grant    <= GW'(NUM_MASTERS-1);
      r_wd_cnt        <= '0;
      r_timeout_count <= '0;
    end else if (r_state == IDLE) begin
      if (w_idle_pick[GW]) begin
        r_grant  <= w_idle_pick[GW-1:0];
        r_wd_cnt <= '0;
        r_state  <= BUSY;
      end
    end else if (w_done) begin
      r_last_grant <= r_grant;
      if (w_timeout && r_timeout_count != 16'hFFFF) r_timeout_count <= r_timeout_count + 16'd1;
      // The served master is masked out, so it always passes through IDLE.
      if (w_next_pick[GW]) begin
        r_grant  <= w_next_pick[GW-1:0];
        r_wd_cnt <= '0;
      end else begin
        r_state <= IDLE;
      end
    end else if (!s_wb_stb_i[r_grant]) begin
      r_last_grant <= r_grant;
      r_state      <= IDLE;
    end else begin
      r_wd_cnt <= r_wd_cnt + WDW'(1);
    end
  end
endmodule
